// File: rtl/key_seq_pkg.sv
// Shared constants and helper functions for the cartridge key/unlock sequencer.
// Helpers work on 16-bit zero-extended values so any state width up to 16 fits.
package key_seq_pkg;

   localparam int unsigned MaxW        = 16;
   localparam int unsigned DefStateW   = 6;
   localparam int unsigned DefAddrW    = 14;
   localparam int unsigned DefKeyLsb   = 4;
   localparam int unsigned DefKeyW     = 4;
   localparam int unsigned DefUnlockLen = 6;
   localparam logic [13:0] DefWinMatch = 14'h1000;
   localparam logic [13:0] DefWinMask  = 14'h3000;
   localparam logic [5:0]  DefSeed     = 6'h01;
   localparam logic [5:0]  DefTaps     = 6'h30;
   localparam logic [5:0]  DefRbMask   = 6'h29;

   function automatic logic [MaxW-1:0] width_mask(input int unsigned w);
      return 16'((32'd1 << w) - 32'd1);
   endfunction

   // Fibonacci step: shift left, feedback parity of tapped bits enters at bit 0.
   function automatic logic [MaxW-1:0] lfsr_next(input logic [MaxW-1:0] st,
                                                 input logic [MaxW-1:0] taps,
                                                 input int unsigned w);
      return {st[MaxW-2:0], ^(st & taps)} & width_mask(w);
   endfunction

   function automatic logic [MaxW-1:0] key_of(input logic [MaxW-1:0] st,
                                              input int unsigned key_w);
      return (st ^ (st >> 2)) & width_mask(key_w);
   endfunction

   function automatic logic parity(input logic [MaxW-1:0] st, input logic [MaxW-1:0] mask);
      return ^(st & mask);
   endfunction

endpackage

// File: rtl/key_seq_lfsr.sv
// LFSR state register: advances on a matching read, falls back to SEED on relock,
// mismatch, or when a read finds the (illegal) all-zero state.
module key_seq_lfsr
   import key_seq_pkg::*;
#(
   parameter int unsigned         STATE_W = DefStateW,
   parameter logic [STATE_W-1:0]  SEED    = DefSeed,
   parameter logic [STATE_W-1:0]  TAPS    = DefTaps
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               relock_i,
   input  logic               rd_i,
   input  logic               match_i,
   output logic               adv_o,
   output logic [STATE_W-1:0] state_o
);

   logic [STATE_W-1:0] state_q;
   logic [MaxW-1:0]    next_ext;

   assign next_ext = lfsr_next(MaxW'(state_q), MaxW'(TAPS), STATE_W);
   // A zero state must never advance, even on a key match.
   assign adv_o    = rd_i & match_i & (|state_q);
   assign state_o  = state_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SEED;
      end else if (relock_i) begin
         state_q <= SEED;
      end else if (adv_o) begin
         state_q <= next_ext[STATE_W-1:0];
      end else if (rd_i) begin
         state_q <= SEED;
      end
   end

endmodule

// File: rtl/key_seq_lock.sv
// Cartridge key/unlock sequencer: window decode, consecutive-match counter,
// unlock flag and same-cycle readback of the pre-update state.
module key_seq_lock
   import key_seq_pkg::*;
#(
   parameter int unsigned         STATE_W    = DefStateW,
   parameter int unsigned         ADDR_W     = DefAddrW,
   parameter logic [ADDR_W-1:0]   WIN_MATCH  = DefWinMatch,
   parameter logic [ADDR_W-1:0]   WIN_MASK   = DefWinMask,
   parameter int unsigned         KEY_LSB    = DefKeyLsb,
   parameter int unsigned         KEY_W      = DefKeyW,
   parameter logic [STATE_W-1:0]  SEED       = DefSeed,
   parameter logic [STATE_W-1:0]  TAPS       = DefTaps,
   parameter int unsigned         UNLOCK_LEN = DefUnlockLen,
   parameter logic [STATE_W-1:0]  RB_MASK    = DefRbMask,
   parameter bit                  STICKY     = 1'b0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               bus_stb_i,
   input  logic               bus_sel_n_i,
   input  logic [ADDR_W-1:0]  bus_addr_i,
   input  logic               bus_rw_i,
   output logic [1:0]         dout_o,
   output logic               dout_oe_o,
   output logic [STATE_W-1:0] state_o,
   output logic [7:0]         step_cnt_o,
   output logic               unlocked_o
);

   localparam logic [7:0] UnlockLen = 8'(UNLOCK_LEN);

   logic            in_win, rd_q, wr_q, match, adv;
   logic [MaxW-1:0] key_exp;
   logic [7:0]      cnt_q, cnt_d, cnt_inc;
   logic            unlocked_q, unlocked_d;

   // rd_q/wr_q are combinational qualifiers, named after the bus decode terms.
   assign in_win  = ~bus_sel_n_i & ((bus_addr_i & WIN_MASK) == WIN_MATCH);
   assign rd_q    = bus_stb_i & in_win & bus_rw_i;
   assign wr_q    = bus_stb_i & in_win & ~bus_rw_i;
   assign key_exp = key_of(MaxW'(state_o), KEY_W);
   assign match   = (bus_addr_i[KEY_LSB +: KEY_W] == key_exp[KEY_W-1:0]);

   key_seq_lfsr #(
      .STATE_W (STATE_W),
      .SEED    (SEED),
      .TAPS    (TAPS)
   ) u_lfsr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .relock_i (wr_q),
      .rd_i     (rd_q),
      .match_i  (match),
      .adv_o    (adv),
      .state_o  (state_o)
   );

   assign cnt_inc = (cnt_q >= UnlockLen) ? UnlockLen : cnt_q + 8'd1;

   always_comb begin
      cnt_d      = cnt_q;
      unlocked_d = unlocked_q;
      if (wr_q) begin
         cnt_d      = 8'd0;
         unlocked_d = 1'b0;
      end else if (adv) begin
         cnt_d      = cnt_inc;
         unlocked_d = unlocked_q | (cnt_inc == UnlockLen);
      end else if (rd_q) begin
         cnt_d      = 8'd0;
         unlocked_d = STICKY ? unlocked_q : 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= 8'd0;
         unlocked_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         unlocked_q <= unlocked_d;
      end
   end

   assign step_cnt_o = cnt_q;
   assign unlocked_o = unlocked_q;
   assign dout_oe_o  = rd_q;
   assign dout_o     = {unlocked_q, parity(MaxW'(state_o), MaxW'(RB_MASK))};

endmodule

// File: tb/tb_key_seq_lock.sv
// Directed bench for key_seq_lock: default and STICKY=1 instances share one bus,
// expected values come from a small reference model through scoreboard queues.
module tb_key_seq_lock;

   logic        clk = 1'b0;
   logic        rst, stb, sel_n, rw;
   logic [13:0] addr;
   logic [1:0]  dout, dout_s;
   logic        oe, oe_s, unl, unl_s;
   logic [5:0]  st, st_s;
   logic [7:0]  cnt, cnt_s;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string      tag;
      logic [5:0] st;
      logic [7:0] cnt;
      logic       unl;
      logic       unls;
   } post_t;

   typedef struct {
      string      tag;
      logic       oe;
      logic [1:0] dout;
      logic [1:0] douts;
   } rb_t;

   post_t post_q[$];
   rb_t   rb_q[$];

   // Reference model; state/count are shared, only the unlock flag differs.
   logic [5:0] m_st;
   logic [7:0] m_cnt;
   logic       m_unl, m_unls;

   always #5 clk = ~clk;

   key_seq_lock u_dut (
      .clk_i(clk), .rst_i(rst), .bus_stb_i(stb), .bus_sel_n_i(sel_n), .bus_addr_i(addr),
      .bus_rw_i(rw), .dout_o(dout), .dout_oe_o(oe), .state_o(st), .step_cnt_o(cnt),
      .unlocked_o(unl)
   );

   key_seq_lock #(.STICKY(1'b1)) u_dut_s (
      .clk_i(clk), .rst_i(rst), .bus_stb_i(stb), .bus_sel_n_i(sel_n), .bus_addr_i(addr),
      .bus_rw_i(rw), .dout_o(dout_s), .dout_oe_o(oe_s), .state_o(st_s), .step_cnt_o(cnt_s),
      .unlocked_o(unl_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic r, input logic s, input logic sn,
                       input logic w, input logic [13:0] a);
      rb_t   rb;
      post_t p;
      logic  win, m_oe, hit;
      @(negedge clk);
      rst = r; stb = s; sel_n = sn; rw = w; addr = a;
      win  = !sn && ((a & 14'h3000) == 14'h1000);
      m_oe = s && win && w;
      rb.tag   = tag;
      rb.oe    = m_oe;
      rb.dout  = {m_unl,  ^(m_st & 6'h29)};
      rb.douts = {m_unls, ^(m_st & 6'h29)};
      rb_q.push_back(rb);
      if (r) begin
         m_st = 6'h01; m_cnt = 8'd0; m_unl = 1'b0; m_unls = 1'b0;
      end else if (s && win && !w) begin
         m_st = 6'h01; m_cnt = 8'd0; m_unl = 1'b0; m_unls = 1'b0;
      end else if (m_oe) begin
         hit = (m_st != 6'h00) && (a[7:4] == (m_st[3:0] ^ m_st[5:2]));
         if (hit) begin
            m_st  = {m_st[4:0], m_st[5] ^ m_st[4]};
            m_cnt = (m_cnt < 8'd6) ? m_cnt + 8'd1 : 8'd6;
            if (m_cnt == 8'd6) begin
               m_unl  = 1'b1;
               m_unls = 1'b1;
            end
         end else begin
            m_st  = 6'h01;
            m_cnt = 8'd0;
            m_unl = 1'b0;
         end
      end
      p = '{tag, m_st, m_cnt, m_unl, m_unls};
      post_q.push_back(p);
      #1;
      rb = rb_q.pop_front();
      check({rb.tag, ".oe"},     32'(oe),     32'(rb.oe));
      check({rb.tag, ".oe_s"},   32'(oe_s),   32'(rb.oe));
      if (rb.oe) begin
         check({rb.tag, ".dout"},   32'(dout),   32'(rb.dout));
         check({rb.tag, ".dout_s"}, 32'(dout_s), 32'(rb.douts));
      end
      @(posedge clk);
      #1;
      p = post_q.pop_front();
      check({p.tag, ".state"},  32'(st),    32'(p.st));
      check({p.tag, ".cnt"},    32'(cnt),   32'(p.cnt));
      check({p.tag, ".unl"},    32'(unl),   32'(p.unl));
      check({p.tag, ".state_s"}, 32'(st_s), 32'(p.st));
      check({p.tag, ".cnt_s"},  32'(cnt_s), 32'(p.cnt));
      check({p.tag, ".unl_s"},  32'(unl_s), 32'(p.unls));
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0000);
   endtask

   task automatic rd(input string tag, input logic [13:0] a);
      step(tag, 1'b0, 1'b1, 1'b0, 1'b1, a);
   endtask

   task automatic unlock_seq(input string tag);
      rd({tag, "1"}, 14'h1010);
      rd({tag, "2"}, 14'h1020);
      rd({tag, "3"}, 14'h1050);
      rd({tag, "4"}, 14'h10A0);
      rd({tag, "5"}, 14'h1040);
      rd({tag, "6"}, 14'h1090);
   endtask

   initial begin
      rst = 1'b1; stb = 1'b0; sel_n = 1'b1; rw = 1'b1; addr = '0;
      m_st = 6'h01; m_cnt = 8'd0; m_unl = 1'b0; m_unls = 1'b0;

      step("reset", 1'b1, 1'b0, 1'b1, 1'b1, 14'h0000);
      step("reset2", 1'b1, 1'b0, 1'b1, 1'b1, 14'h0000);
      check("reset.state_abs", 32'(st), 32'h01);
      check("reset.cnt_abs", 32'(cnt), 32'h00);
      check("reset.unl_abs", 32'(unl), 32'h0);

      // Readback of the seed state: parity(0x01 & 0x29) = 1.
      rd("unl1", 14'h1010);
      check("unl1.state_abs", 32'(st), 32'h02);
      rd("unl2", 14'h1020);
      rd("unl3", 14'h1050);
      rd("unl4", 14'h10A0);
      rd("unl5", 14'h1040);
      check("unl5.state_abs", 32'(st), 32'h21);
      check("unl5.locked", 32'(unl), 32'h0);
      rd("unl6", 14'h1090);
      check("unl6.state_abs", 32'(st), 32'h03);
      check("unl6.cnt_abs", 32'(cnt), 32'd6);
      check("unl6.unl_abs", 32'(unl), 32'h1);
      rd("sat", 14'h1030);
      check("sat.cnt_abs", 32'(cnt), 32'd6);

      step("out_lo", 1'b0, 1'b1, 1'b0, 1'b1, 14'h0010);
      step("out_hi", 1'b0, 1'b1, 1'b0, 1'b1, 14'h3010);
      step("sel_off", 1'b0, 1'b1, 1'b1, 1'b1, 14'h1010);
      step("no_stb", 1'b0, 1'b0, 1'b0, 1'b1, 14'h1010);
      step("wr_outside", 1'b0, 1'b1, 1'b0, 1'b0, 14'h0000);
      idle("idle");

      step("relock", 1'b0, 1'b1, 1'b0, 1'b0, 14'h1000);
      check("relock.state_abs", 32'(st), 32'h01);
      check("relock.unl_abs", 32'(unl), 32'h0);

      rd("mm1", 14'h1010);
      rd("mm2", 14'h1020);
      rd("mm3", 14'h1050);
      check("mm3.state_abs", 32'(st), 32'h08);
      rd("mm_bad", 14'h1030);
      check("mm_bad.state_abs", 32'(st), 32'h01);
      check("mm_bad.cnt_abs", 32'(cnt), 32'h00);
      rd("mm_again", 14'h1010);
      check("mm_again.state_abs", 32'(st), 32'h02);

      step("relock2", 1'b0, 1'b1, 1'b0, 1'b0, 14'h1000);
      unlock_seq("sk");
      rd("sk_bad", 14'h1050);
      check("sk_bad.unl_abs", 32'(unl), 32'h0);
      check("sk_bad.unl_s_abs", 32'(unl_s), 32'h1);
      check("sk_bad.state_s_abs", 32'(st_s), 32'h01);
      rd("sk_good", 14'h1010);
      step("sk_relock", 1'b0, 1'b1, 1'b0, 1'b0, 14'h1000);
      check("sk_relock.unl_s_abs", 32'(unl_s), 32'h0);

      rd("rs1", 14'h1010);
      rd("rs2", 14'h1020);
      rd("rs3", 14'h1050);
      rd("rs4", 14'h10A0);
      check("rs4.cnt_abs", 32'(cnt), 32'd4);
      step("rs_rst_rd", 1'b1, 1'b1, 1'b0, 1'b1, 14'h1010);
      check("rs_rst_rd.state_abs", 32'(st), 32'h01);
      check("rs_rst_rd.cnt_abs", 32'(cnt), 32'h00);
      step("rs_rel", 1'b0, 1'b0, 1'b1, 1'b1, 14'h0000);
      rd("rs_after", 14'h1010);
      check("rs_after.state_abs", 32'(st), 32'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
